// File: rtl/level_3_merge.sv
// ============================================================================
// level_3_merge : merge-sort stage 3, merges four sorted 4-word runs into two sorted 8-word runs
// Revision      : 1.0
// ============================================================================
`default_nettype none

module level_3_merge #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [16*DATA_WIDTH-1:0] idata,
  input  logic                     ivalid,
  output logic                     busy,
  output logic [16*DATA_WIDTH-1:0] odata,
  output logic                     ovalid
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] run_buf   [4][4];
  logic [2:0]            remaining [4];
  logic [2:0]            cnt;
  logic                  take_a    [2];
  logic [DATA_WIDTH-1:0] taken     [2];

  // Lane l merges run 2l (A) against run 2l+1 (B); ties and an empty A both fall to B.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      take_a[l] = (remaining[2*l+1] == 3'd0) ||
                  ((remaining[2*l] != 3'd0) && (run_buf[2*l][3] > run_buf[2*l+1][3]));
      taken[l]  = take_a[l] ? run_buf[2*l][3] : run_buf[2*l+1][3];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      ovalid <= 1'b0;
      odata  <= '0;
      cnt    <= 3'd0;
      for (int r = 0; r < 4; r++) begin
        remaining[r] <= 3'd0;
        for (int j = 0; j < 4; j++) run_buf[r][j] <= '0;
      end
    end else if (state == IDLE) begin
      ovalid <= 1'b0;
      if (ivalid) begin
        for (int r = 0; r < 4; r++) begin
          remaining[r] <= 3'd4;
          for (int j = 0; j < 4; j++) run_buf[r][j] <= idata[(4*r+j)*DATA_WIDTH +: DATA_WIDTH];
        end
        cnt   <= 3'd0;
        busy  <= 1'b1;
        state <= MERGE;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        // Consume the head of the chosen run: shift toward index 3, zero fill at index 0.
        for (int r = 2*l; r < 2*l + 2; r++) begin
          if ((r == 2*l) == take_a[l]) begin
            run_buf[r][3] <= run_buf[r][2];
            run_buf[r][2] <= run_buf[r][1];
            run_buf[r][1] <= run_buf[r][0];
            run_buf[r][0] <= '0;
            remaining[r]  <= remaining[r] - 3'd1;
          end
        end
        odata[l*8*DATA_WIDTH +: 8*DATA_WIDTH] <=
          {odata[l*8*DATA_WIDTH +: 7*DATA_WIDTH], taken[l]};
      end
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) begin
        ovalid <= 1'b1;
        busy   <= 1'b0;
        state  <= IDLE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_level_3_merge.sv
// Bench for level_3_merge: directed scenarios plus random sorted blocks against a sort-based model.
`default_nettype none

module tb_level_3_merge;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] idata;
  logic         ivalid;
  logic         busy;
  logic [127:0] odata;
  logic         ovalid;

  int passed = 0;
  int total  = 0;

  level_3_merge #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .idata (idata),
    .ivalid(ivalid),
    .busy  (busy),
    .odata (odata),
    .ovalid(ovalid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Merging two sorted runs equals sorting their union: each 8-word lane is sorted ascending.
  function automatic logic [127:0] ref_merge(input logic [127:0] d);
    logic [127:0] r;
    int v[8];
    int t;
    r = '0;
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 8; i++) v[i] = int'(d[(8*l+i)*8 +: 8]);
      for (int i = 1; i < 8; i++)
        for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
          t = v[j]; v[j] = v[j-1]; v[j-1] = t;
        end
      for (int i = 0; i < 8; i++) r[(8*l+i)*8 +: 8] = v[i][7:0];
    end
    return r;
  endfunction

  function automatic logic [127:0] rand_block();
    logic [127:0] b;
    int w[4];
    int t;
    int maxv;
    b = '0;
    maxv = ($urandom_range(0, 1) == 0) ? 3 : 255;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) w[i] = $urandom_range(0, maxv);
      for (int i = 1; i < 4; i++)
        for (int j = i; j > 0 && w[j-1] > w[j]; j--) begin
          t = w[j]; w[j] = w[j-1]; w[j-1] = t;
        end
      for (int i = 0; i < 4; i++) b[(4*r+i)*8 +: 8] = w[i][7:0];
    end
    return b;
  endfunction

  function automatic logic [127:0] garbage();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_block(input logic [127:0] blk, input string tag);
    idata  = blk;
    ivalid = 1'b1;
    tick();
    ivalid = 1'b0;
    idata  = garbage();
    check({tag, " busy"}, 128'(busy), 128'(1'b1));
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("%s ovalid@E%0d", tag, k), 128'(ovalid), 128'(k == 8));
    end
    check({tag, " odata"}, odata, ref_merge(blk));
    check({tag, " busy_done"}, 128'(busy), 128'(1'b0));
    tick();
    check({tag, " ovalid_drop"}, 128'(ovalid), 128'(1'b0));
    check({tag, " odata_hold"}, odata, ref_merge(blk));
  endtask

  logic [127:0] blk_s2;
  logic [127:0] blk_s3;
  logic [127:0] blk_s4;
  logic [127:0] blks [4];

  initial begin
    blk_s2 = {8'd35, 8'd25, 8'd15, 8'd5, 8'd40, 8'd30, 8'd20, 8'd10,
              8'd35, 8'd25, 8'd15, 8'd5, 8'd40, 8'd30, 8'd20, 8'd10};
    blk_s3 = {8'd5, 8'd5, 8'd0, 8'd0, 8'd5, 8'd5, 8'd0, 8'd0,
              8'd4, 8'd3, 8'd2, 8'd1, 8'd9, 8'd8, 8'd7, 8'd6};
    blk_s4 = {{8{8'd255}}, 8'd255, 8'd255, 8'd0, 8'd0, {4{8'd255}}};

    // Reset state
    rst_n  = 1'b0;
    ivalid = 1'b0;
    idata  = '0;
    tick();
    tick();
    check("rst odata", odata, '0);
    check("rst ovalid", 128'(ovalid), 128'(1'b0));
    check("rst busy", 128'(busy), 128'(1'b0));
    rst_n = 1'b1;
    tick();

    // Interleaved runs
    run_block(blk_s2, "s2");
    check("s2 lane0", 128'(odata[63:0]),
          128'({8'd40, 8'd35, 8'd30, 8'd25, 8'd20, 8'd15, 8'd10, 8'd5}));
    check("s2 lane1", 128'(odata[127:64]),
          128'({8'd40, 8'd35, 8'd30, 8'd25, 8'd20, 8'd15, 8'd10, 8'd5}));

    // Exhaustion and ties, with tie direction visible in the run counters
    idata  = blk_s3;
    ivalid = 1'b1;
    tick();
    ivalid = 1'b0;
    tick();
    check("s3 rem2@E1", 128'(dut.remaining[2]), 128'(3'd4));
    check("s3 rem3@E1", 128'(dut.remaining[3]), 128'(3'd3));
    tick();
    check("s3 rem2@E2", 128'(dut.remaining[2]), 128'(3'd4));
    check("s3 rem3@E2", 128'(dut.remaining[3]), 128'(3'd2));
    tick();
    check("s3 rem2@E3", 128'(dut.remaining[2]), 128'(3'd3));
    for (int k = 4; k <= 8; k++) tick();
    check("s3 ovalid", 128'(ovalid), 128'(1'b1));
    check("s3 lane0", 128'(odata[63:0]),
          128'({8'd9, 8'd8, 8'd7, 8'd6, 8'd4, 8'd3, 8'd2, 8'd1}));
    check("s3 lane1", 128'(odata[127:64]),
          128'({8'd5, 8'd5, 8'd5, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0}));
    tick();

    // Max values
    run_block(blk_s4, "s4");
    check("s4 lane0", 128'(odata[63:0]), 128'({{6{8'd255}}, 8'd0, 8'd0}));
    check("s4 lane1", 128'(odata[127:64]), 128'({8{8'd255}}));

    // Back-to-back with ivalid held high and idata scrambled during MERGE
    for (int n = 0; n < 4; n++) blks[n] = rand_block();
    ivalid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      idata = blks[n];
      tick();
      check($sformatf("b2b%0d busy", n), 128'(busy), 128'(1'b1));
      for (int k = 1; k <= 8; k++) begin
        idata = garbage();
        tick();
        check($sformatf("b2b%0d ovalid@E%0d", n, k), 128'(ovalid), 128'(k == 8));
      end
      check($sformatf("b2b%0d odata", n), odata, ref_merge(blks[n]));
    end
    ivalid = 1'b0;
    tick();
    check("b2b tail ovalid", 128'(ovalid), 128'(1'b0));

    // Random isolated blocks
    for (int n = 0; n < 6; n++) run_block(rand_block(), $sformatf("rnd%0d", n));

    // Reset mid-MERGE at step 4
    idata  = rand_block();
    ivalid = 1'b1;
    tick();
    ivalid = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    #3 rst_n = 1'b0;
    #1;
    check("rstmid odata", odata, '0);
    check("rstmid ovalid", 128'(ovalid), 128'(1'b0));
    check("rstmid busy", 128'(busy), 128'(1'b0));
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rstmid no_ovalid%0d", k), 128'(ovalid), 128'(1'b0));
    end
    rst_n = 1'b1;
    tick();
    check("post_rst ovalid", 128'(ovalid), 128'(1'b0));
    run_block(blk_s2, "post_rst");
    check("post_rst lane0", 128'(odata[63:0]),
          128'({8'd40, 8'd35, 8'd30, 8'd25, 8'd20, 8'd15, 8'd10, 8'd5}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
